// File: rtl/hstx_lane_ctrl.sv
// Per-lane HS burst sequencer: walks the LP entry sequence, gates SOT/TxValid into hstx_fsm,
// paces the requester with one TxReadyHS per byte slot, then closes the burst back to Stop.
module hstx_lane_ctrl #(
    parameter int CNT_W       = 8,
    parameter int T_LPX       = 16,
    parameter int T_HS_PREP   = 12,
    parameter int HS_LEAD     = 23,
    parameter int BYTE_CYCLES = 8,
    parameter int T_HS_TRAIL  = 20,
    parameter int T_HS_EXIT   = 24
) (
    input  logic       TxDDRClkHS,
    input  logic       TxRst,
    input  logic       TxRequestHS,
    output logic       TxReadyHS,
    output logic       SOT,
    output logic       TxValid,
    output logic       HS_En,
    output logic       LP_En,
    output logic       LP_Dp,
    output logic       LP_Dn,
    output logic       Stopstate,
    output logic [2:0] CtrlState
);

    localparam int BC_W = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] LPX_LOAD   = CNT_W'(T_LPX - 1);
    localparam logic [CNT_W-1:0] PREP_LOAD  = CNT_W'(T_HS_PREP - 1);
    localparam logic [CNT_W-1:0] LEAD_LOAD  = CNT_W'(HS_LEAD - 1);
    localparam logic [CNT_W-1:0] TRAIL_LOAD = CNT_W'(T_HS_TRAIL - 1);
    localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(T_HS_EXIT - 1);
    localparam logic [BC_W-1:0]  BYTE_LAST  = BC_W'(BYTE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_STOP      = 3'd0,
        ST_LP_RQST   = 3'd1,
        ST_LP_BRIDGE = 3'd2,
        ST_HS_PREP   = 3'd3,
        ST_HS_GO     = 3'd4,
        ST_HS_DATA   = 3'd5,
        ST_HS_TRAIL  = 3'd6,
        ST_HS_EXIT   = 3'd7
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_next;
    logic [BC_W-1:0]  byte_cnt;
    logic [BC_W-1:0]  byte_cnt_next;
    logic             timer_done;
    logic             slot_end;

    assign timer_done = (timer == '0);
    assign slot_end   = (byte_cnt == BYTE_LAST);

    always_ff @(posedge TxDDRClkHS) begin
        if (TxRst) begin
            state    <= ST_STOP;
            timer    <= '0;
            byte_cnt <= '0;
        end else begin
            state    <= state_next;
            timer    <= timer_next;
            byte_cnt <= byte_cnt_next;
        end
    end

    // Each timed state loads length-1 on entry and exits on the cycle the timer reads zero.
    always_comb begin
        state_next    = state;
        timer_next    = timer_done ? '0 : timer - CNT_W'(1);
        byte_cnt_next = '0;
        case (state)
            ST_STOP: begin
                if (TxRequestHS) begin
                    state_next = ST_LP_RQST;
                    timer_next = LPX_LOAD;
                end
            end
            ST_LP_RQST: begin
                if (timer_done) begin
                    state_next = ST_LP_BRIDGE;
                    timer_next = LPX_LOAD;
                end
            end
            ST_LP_BRIDGE: begin
                if (timer_done) begin
                    state_next = ST_HS_PREP;
                    timer_next = PREP_LOAD;
                end
            end
            ST_HS_PREP: begin
                if (timer_done) begin
                    state_next = ST_HS_GO;
                    timer_next = LEAD_LOAD;
                end
            end
            ST_HS_GO: begin
                if (timer_done) begin
                    if (TxRequestHS) begin
                        state_next = ST_HS_DATA;
                        timer_next = '0;
                    end else begin
                        state_next = ST_HS_TRAIL;
                        timer_next = TRAIL_LOAD;
                    end
                end
            end
            ST_HS_DATA: begin
                // The request is only looked at on the last cycle of a byte slot.
                byte_cnt_next = slot_end ? '0 : byte_cnt + BC_W'(1);
                if (slot_end && !TxRequestHS) begin
                    state_next = ST_HS_TRAIL;
                    timer_next = TRAIL_LOAD;
                end
            end
            ST_HS_TRAIL: begin
                if (timer_done) begin
                    state_next = ST_HS_EXIT;
                    timer_next = EXIT_LOAD;
                end
            end
            ST_HS_EXIT: begin
                if (timer_done) begin
                    state_next = ST_STOP;
                end
            end
            default: begin
                state_next = ST_STOP;
                timer_next = '0;
            end
        endcase
    end

    // Line levels decode purely from the registered state; LP levels are parked low while LP is off.
    always_comb begin
        LP_En     = 1'b0;
        LP_Dp     = 1'b0;
        LP_Dn     = 1'b0;
        HS_En     = 1'b0;
        SOT       = 1'b0;
        TxValid   = 1'b0;
        Stopstate = 1'b0;
        case (state)
            ST_STOP: begin
                LP_En     = 1'b1;
                LP_Dp     = 1'b1;
                LP_Dn     = 1'b1;
                Stopstate = 1'b1;
            end
            ST_LP_RQST: begin
                LP_En = 1'b1;
                LP_Dn = 1'b1;
            end
            ST_LP_BRIDGE: begin
                LP_En = 1'b1;
            end
            ST_HS_PREP: begin
                LP_En = 1'b1;
                HS_En = 1'b1;
            end
            ST_HS_GO, ST_HS_DATA: begin
                HS_En   = 1'b1;
                SOT     = 1'b1;
                TxValid = 1'b1;
            end
            ST_HS_TRAIL: begin
                HS_En = 1'b1;
            end
            ST_HS_EXIT: begin
                LP_En = 1'b1;
                LP_Dp = 1'b1;
                LP_Dn = 1'b1;
            end
            default: begin
                LP_En     = 1'b1;
                LP_Dp     = 1'b1;
                LP_Dn     = 1'b1;
                Stopstate = 1'b1;
            end
        endcase
    end

    assign TxReadyHS = (state == ST_HS_DATA) && slot_end && TxRequestHS;
    assign CtrlState = state;

endmodule

// File: tb/tb_hstx_lane_ctrl.sv
// Directed bench for hstx_lane_ctrl: a segment table walks reset, a one-byte burst and an
// early-drop burst cycle by cycle; hand sequences cover multi-byte pacing, back-to-back and reset.
module tb_hstx_lane_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       ready;
    logic       sot;
    logic       txvalid;
    logic       hs_en;
    logic       lp_en;
    logic       lp_dp;
    logic       lp_dn;
    logic       stopstate;
    logic [2:0] ctrl_state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       req;
        int         cycles;
        logic [2:0] st;
        logic       rdy;
    } seg_t;

    seg_t segs[$];

    hstx_lane_ctrl dut (
        .TxDDRClkHS (clk),
        .TxRst      (rst),
        .TxRequestHS(req),
        .TxReadyHS  (ready),
        .SOT        (sot),
        .TxValid    (txvalid),
        .HS_En      (hs_en),
        .LP_En      (lp_en),
        .LP_Dp      (lp_dp),
        .LP_Dn      (lp_dn),
        .Stopstate  (stopstate),
        .CtrlState  (ctrl_state)
    );

    always #5 clk = ~clk;

    // Packed as {state, LP_En, LP_Dp, LP_Dn, HS_En, SOT, TxValid, Stopstate, TxReadyHS}.
    function automatic logic [10:0] expOut(input logic [2:0] st, input logic rdy);
        logic [10:0] o;
        case (st)
            3'd0:    o = {3'd0, 3'b111, 1'b0, 2'b00, 1'b1, rdy};
            3'd1:    o = {3'd1, 3'b101, 1'b0, 2'b00, 1'b0, rdy};
            3'd2:    o = {3'd2, 3'b100, 1'b0, 2'b00, 1'b0, rdy};
            3'd3:    o = {3'd3, 3'b100, 1'b1, 2'b00, 1'b0, rdy};
            3'd4:    o = {3'd4, 3'b000, 1'b1, 2'b11, 1'b0, rdy};
            3'd5:    o = {3'd5, 3'b000, 1'b1, 2'b11, 1'b0, rdy};
            3'd6:    o = {3'd6, 3'b000, 1'b1, 2'b00, 1'b0, rdy};
            default: o = {3'd7, 3'b111, 1'b0, 2'b00, 1'b0, rdy};
        endcase
        return o;
    endfunction

    task automatic applyStimulus(input logic r, input logic q);
        @(posedge clk);
        #1;
        rst = r;
        req = q;
        #1;
    endtask

    // LP_Dp/LP_Dn are don't-care whenever LP_En is expected low.
    task automatic checkOutput(input string tag, input int idx, input logic [10:0] exp);
        logic [10:0] act;
        logic [10:0] mask;
        act  = {ctrl_state, lp_en, lp_dp, lp_dn, hs_en, sot, txvalid, stopstate, ready};
        mask = exp[7] ? 11'h7FF : 11'h79F;
        checks++;
        if ((act & mask) !== (exp & mask)) begin
            failures++;
            $display("[TB] FAIL %s[%0d]: got %b expected %b", tag, idx, act, exp);
        end
    endtask

    task automatic checkCount(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic addSeg(input logic r, input logic q, input int n, input logic [2:0] st,
                          input logic rdy);
        seg_t s;
        s.rst = r; s.req = q; s.cycles = n; s.st = st; s.rdy = rdy;
        segs.push_back(s);
    endtask

    initial begin
        int pulses, cyc, go_idx, data_idx, trail_idx, first_pulse, last_pulse;
        int trail_n, exit_n;
        bit sot_ok, gap_ok;

        rst = 1'b1;
        req = 1'b0;

        // Reset, then a one-byte burst, then an empty burst where the request drops in LP_BRIDGE.
        addSeg(1, 0, 10, 3'd0, 0);
        addSeg(0, 1,  1, 3'd0, 0);
        addSeg(0, 1, 16, 3'd1, 0);
        addSeg(0, 1, 16, 3'd2, 0);
        addSeg(0, 1, 12, 3'd3, 0);
        addSeg(0, 1, 23, 3'd4, 0);
        addSeg(0, 1,  7, 3'd5, 0);
        addSeg(0, 1,  1, 3'd5, 1);
        addSeg(0, 0,  8, 3'd5, 0);
        addSeg(0, 0, 20, 3'd6, 0);
        addSeg(0, 0, 24, 3'd7, 0);
        addSeg(0, 0,  3, 3'd0, 0);
        addSeg(0, 1,  1, 3'd0, 0);
        addSeg(0, 1, 16, 3'd1, 0);
        addSeg(0, 1,  5, 3'd2, 0);
        addSeg(0, 0, 11, 3'd2, 0);
        addSeg(0, 0, 12, 3'd3, 0);
        addSeg(0, 0, 23, 3'd4, 0);
        addSeg(0, 0, 20, 3'd6, 0);
        addSeg(0, 0, 24, 3'd7, 0);
        addSeg(0, 0,  2, 3'd0, 0);

        for (int s = 0; s < segs.size(); s++) begin
            for (int c = 0; c < segs[s].cycles; c++) begin
                applyStimulus(segs[s].rst, segs[s].req);
                checkOutput($sformatf("seg%0d", s), c, expOut(segs[s].st, segs[s].rdy));
            end
        end

        // Four-byte burst: request held until the fourth TxReadyHS.
        pulses = 0; cyc = 0; go_idx = -1; data_idx = -1; trail_idx = -1;
        first_pulse = -1; last_pulse = -1; sot_ok = 1; gap_ok = 1;
        while (cyc < 400 && trail_idx < 0) begin
            applyStimulus(0, pulses < 4);
            if (ctrl_state == 3'd4 && go_idx < 0) go_idx = cyc;
            if (ctrl_state == 3'd5 && data_idx < 0) data_idx = cyc;
            if ((ctrl_state == 3'd4 || ctrl_state == 3'd5) && !(sot && txvalid)) sot_ok = 0;
            if (ready) begin
                if (last_pulse >= 0 && cyc - last_pulse != 8) gap_ok = 0;
                if (first_pulse < 0) first_pulse = cyc;
                last_pulse = cyc;
                pulses++;
            end
            if (ctrl_state == 3'd6) trail_idx = cyc;
            cyc++;
        end
        checkCount("burst4_reached_trail", int'(trail_idx >= 0), 1);
        checkCount("burst4_pulses", pulses, 4);
        checkCount("burst4_pulse_spacing", int'(gap_ok), 1);
        checkCount("burst4_first_pulse_offset", first_pulse - data_idx, 7);
        checkCount("burst4_sot_continuous", int'(sot_ok), 1);
        checkCount("burst4_go_to_trail", trail_idx - go_idx, 23 + 5 * 8);
        checkCount("burst4_sot_at_trail", int'({sot, txvalid}), 0);

        // Back-to-back: request goes high in HS_TRAIL and is held through HS_EXIT.
        trail_n = 1; exit_n = 0; cyc = 0;
        while (cyc < 100 && (ctrl_state == 3'd6 || ctrl_state == 3'd7)) begin
            applyStimulus(0, 1);
            if (ctrl_state == 3'd6) trail_n++;
            else if (ctrl_state == 3'd7) exit_n++;
            cyc++;
        end
        checkCount("b2b_trail_cycles", trail_n, 20);
        checkCount("b2b_exit_cycles", exit_n, 24);
        checkOutput("b2b_stop", 0, expOut(3'd0, 0));
        applyStimulus(0, 1);
        checkOutput("b2b_lp_rqst", 0, expOut(3'd1, 0));

        // Mid-burst reset: run into HS_DATA with the request still high, then assert TxRst.
        cyc = 0;
        while (cyc < 200 && ctrl_state != 3'd5) begin
            applyStimulus(0, 1);
            cyc++;
        end
        checkCount("rst_reached_data", int'(ctrl_state == 3'd5), 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1);
        applyStimulus(1, 1);
        checkOutput("rst_pre_edge", 0, expOut(3'd5, 0));
        applyStimulus(1, 1);
        checkOutput("rst_applied", 0, expOut(3'd0, 0));
        applyStimulus(0, 0);
        checkOutput("rst_released", 0, expOut(3'd0, 0));
        applyStimulus(0, 0);
        checkOutput("rst_idle", 0, expOut(3'd0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
